pipe_hazard_ctrl: RTL and testbench

//  Hazard/forwarding/halt controller for the 5-stage pipeline (IF/ID/EX/MEM/WB); successor to the ideal,

---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_fwd_sel.sv | 44 ++++
 rtl/pipe_hazard_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/forwarding/halt controller.
// Forwarding source codes and the halt sequencer states.
package pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } halt_st_t;

endpackage

// File: rtl/pipe_fwd_sel.sv
// Per-operand forwarding source selector.
// Youngest producer wins; a load still in EX flags a hazard instead.
module pipe_fwd_sel
  import pipe_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] rs,
  input  logic            use_op,
  input  logic [RA_W-1:0] ex_rw,
  input  logic            ex_wr,
  input  logic            ex_load,
  input  logic [RA_W-1:0] mem_rw,
  input  logic            mem_wr,
  input  logic [RA_W-1:0] wb_rw,
  input  logic            wb_wr,
  output logic [1:0]      fwd,
  output logic            load_haz
);

  logic live;
  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  // r0 never carries a value worth forwarding
  assign live    = use_op && (rs != '0);
  assign ex_hit  = live && ex_wr  && (ex_rw  == rs);
  assign mem_hit = live && mem_wr && (mem_rw == rs);
  assign wb_hit  = live && wb_wr  && (wb_rw  == rs);

  always_comb begin
    fwd = FWD_RF;
    priority case (1'b1)
      ex_hit:  fwd = FWD_EX;
      mem_hit: fwd = FWD_MEM;
      wb_hit:  fwd = FWD_WB;
      default: fwd = FWD_RF;
    endcase
  end

  assign load_haz = ex_hit && ex_load;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and halt sequencing for the 5-stage pipeline,
// with saturating performance counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int RA_W      = 5,
  parameter int CNT_W     = 32,
  parameter int LOAD_BUBB = 1
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_halt,
  input  logic [RA_W-1:0]  ex_rw,
  input  logic [RA_W-1:0]  mem_rw,
  input  logic [RA_W-1:0]  wb_rw,
  input  logic             ex_wr,
  input  logic             mem_wr,
  input  logic             wb_wr,
  input  logic             ex_load,
  input  logic             ex_redirect,
  input  logic             wb_halt,
  input  logic             resume,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  halt_st_t   state;
  logic       haz_a;
  logic       haz_b;
  logic [1:0] bub_cnt;
  logic       counting;
  logic       stall;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic             en
  );
    return (en && (v != '1)) ? v + {{(CNT_W-1){1'b0}}, 1'b1} : v;
  endfunction

  pipe_fwd_sel #(.RA_W(RA_W)) u_fwd_a (
    .rs       (id_rs),
    .use_op   (id_use_rs),
    .ex_rw    (ex_rw),
    .ex_wr    (ex_wr),
    .ex_load  (ex_load),
    .mem_rw   (mem_rw),
    .mem_wr   (mem_wr),
    .wb_rw    (wb_rw),
    .wb_wr    (wb_wr),
    .fwd      (fwd_a),
    .load_haz (haz_a)
  );

  pipe_fwd_sel #(.RA_W(RA_W)) u_fwd_b (
    .rs       (id_rt),
    .use_op   (id_use_rt),
    .ex_rw    (ex_rw),
    .ex_wr    (ex_wr),
    .ex_load  (ex_load),
    .mem_rw   (mem_rw),
    .mem_wr   (mem_wr),
    .wb_rw    (wb_rw),
    .wb_wr    (wb_wr),
    .fwd      (fwd_b),
    .load_haz (haz_b)
  );

  // While extra bubbles count down the hazard is not looked at again
  assign counting = (bub_cnt != 2'd0);
  assign stall    = (state == RUN) && !ex_redirect
                 && (counting || haz_a || haz_b);

  generate
    if (LOAD_BUBB > 1) begin : g_bub
      always_ff @(posedge clk or posedge RST) begin
        if (RST)              bub_cnt <= 2'd0;
        else if (ex_redirect) bub_cnt <= 2'd0;
        else if (counting)    bub_cnt <= bub_cnt - 2'd1;
        else if (stall)       bub_cnt <= 2'(LOAD_BUBB - 1);
      end
    end else begin : g_no_bub
      assign bub_cnt = 2'd0;
    end
  endgenerate

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    unique case (state)
      RUN: begin
        if (ex_redirect) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (stall) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
      end
      DRAIN: begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b1;
      end
      HALTED: begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state  <= RUN;
      halted <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (id_halt && !ex_redirect && !stall)
            state <= DRAIN;
        end
        DRAIN: begin
          if (wb_halt) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED: begin
          if (resume) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cyc_cnt   <= sat_inc(cyc_cnt, !halted);
      stall_cnt <= sat_inc(stall_cnt, stall);
      flush_cnt <= sat_inc(flush_cnt, ex_redirect);
      instr_cnt <= sat_inc(instr_cnt,
                           (wb_wr || wb_halt) && !halted);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with CNT_W=4, LOAD_BUBB=1.
// Expectations are queued on drive and popped when outputs settle.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       RST;
  logic [4:0] id_rs, id_rt, ex_rw, mem_rw, wb_rw;
  logic       id_use_rs, id_use_rt, id_halt;
  logic       ex_wr, mem_wr, wb_wr, ex_load;
  logic       ex_redirect, wb_halt, resume;
  logic       pc_en, ifid_en, ifid_flush, idex_flush, halted;
  logic [1:0] fwd_a, fwd_b;
  logic [3:0] cyc_cnt, stall_cnt, flush_cnt, instr_cnt;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.RA_W(5), .CNT_W(4), .LOAD_BUBB(1)) dut (
    .clk         (clk),
    .RST         (RST),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_halt     (id_halt),
    .ex_rw       (ex_rw),
    .mem_rw      (mem_rw),
    .wb_rw       (wb_rw),
    .ex_wr       (ex_wr),
    .mem_wr      (mem_wr),
    .wb_wr       (wb_wr),
    .ex_load     (ex_load),
    .ex_redirect (ex_redirect),
    .wb_halt     (wb_halt),
    .resume      (resume),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .halted      (halted),
    .cyc_cnt     (cyc_cnt),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt),
    .instr_cnt   (instr_cnt)
  );

  task automatic want(string tag, logic [31:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic chk(logic [31:0] obs);
    exp_t e;
    n_total++;
    if (sb.size() == 0) begin
      $error("FAIL sb_empty: got %0h want <queued value>", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.v) n_pass++;
    else $error("FAIL %s: got %0h want %0h", e.tag, obs, e.v);
  endtask

  task automatic clr_in();
    id_rs = 0; id_rt = 0; ex_rw = 0; mem_rw = 0; wb_rw = 0;
    id_use_rs = 0; id_use_rt = 0; id_halt = 0;
    ex_wr = 0; mem_wr = 0; wb_wr = 0; ex_load = 0;
    ex_redirect = 0; wb_halt = 0; resume = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  initial begin
    clr_in();
    RST = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    want("rst_pc_en", 1);      chk(pc_en);
    want("rst_ifid_en", 1);    chk(ifid_en);
    want("rst_ifid_flush", 0); chk(ifid_flush);
    want("rst_idex_flush", 0); chk(idex_flush);
    want("rst_fwd_a", 0);      chk(fwd_a);
    want("rst_halted", 0);     chk(halted);
    want("rst_cyc", 0);        chk(cyc_cnt);
    want("rst_instr", 0);      chk(instr_cnt);
    RST = 1'b0;

    // forwarding priority, all combinational
    id_rs = 3; id_use_rs = 1; ex_rw = 3; ex_wr = 1;
    want("fwd_ex", 1); want("fwd_ex_nostall", 1);
    #1; chk(fwd_a); chk(pc_en);
    ex_wr = 0; mem_rw = 3; mem_wr = 1;
    want("fwd_mem", 2);
    #1; chk(fwd_a);
    mem_wr = 0; wb_rw = 3; wb_wr = 1;
    want("fwd_wb", 3);
    #1; chk(fwd_a);
    ex_wr = 1; mem_wr = 1;
    want("fwd_prio_all", 1);
    #1; chk(fwd_a);
    ex_wr = 0;
    want("fwd_prio_mem_wb", 2);
    #1; chk(fwd_a);
    id_use_rs = 0;
    want("fwd_use_gate", 0);
    #1; chk(fwd_a);
    clr_in();
    id_rs = 0; id_use_rs = 1; ex_rw = 0; ex_wr = 1; ex_load = 1;
    want("fwd_r0", 0); want("r0_nostall", 1); want("r0_no_bubble", 0);
    #1; chk(fwd_a); chk(pc_en); chk(idex_flush);
    clr_in();

    // load-use, one bubble
    do_reset();
    id_rt = 5; id_use_rt = 1; ex_rw = 5; ex_wr = 1; ex_load = 1;
    want("lu_pc_en", 0); want("lu_ifid_en", 0);
    want("lu_idex_flush", 1); want("lu_ifid_flush", 0);
    #1; chk(pc_en); chk(ifid_en); chk(idex_flush); chk(ifid_flush);
    tick();
    want("lu_stall_cnt", 1); chk(stall_cnt);
    ex_wr = 0; ex_load = 0; mem_rw = 5; mem_wr = 1;
    want("lu_after_pc_en", 1); want("lu_after_fwd_b", 2);
    want("lu_after_idex", 0);
    #1; chk(pc_en); chk(fwd_b); chk(idex_flush);
    tick();
    want("lu_stall_hold", 1); chk(stall_cnt);
    clr_in();

    // redirect overrides a load-use stall
    do_reset();
    id_rt = 5; id_use_rt = 1; ex_rw = 5; ex_wr = 1; ex_load = 1;
    ex_redirect = 1;
    want("rd_ifid_flush", 1); want("rd_idex_flush", 1);
    want("rd_pc_en", 1);
    #1; chk(ifid_flush); chk(idex_flush); chk(pc_en);
    tick();
    want("rd_stall_cnt", 0); want("rd_flush_cnt", 1);
    chk(stall_cnt); chk(flush_cnt);
    clr_in();

    // halt coincident with redirect is dropped
    do_reset();
    id_halt = 1; ex_redirect = 1;
    tick();
    clr_in();
    want("hr_stay_run", 1); want("hr_no_flush", 0);
    #1; chk(pc_en); chk(ifid_flush);

    // halt / drain / resume
    do_reset();
    id_halt = 1;
    want("h_run_pc_en", 1);
    #1; chk(pc_en);
    tick();
    id_halt = 0;
    want("drain_pc_en", 0); want("drain_ifid_en", 0);
    want("drain_ifid_flush", 1);
    #1; chk(pc_en); chk(ifid_en); chk(ifid_flush);
    tick();
    tick();
    wb_halt = 1;
    tick();
    wb_halt = 0;
    want("h_halted", 1); want("h_cyc", 4); want("h_instr", 1);
    want("h_pc_en", 0);
    chk(halted); chk(cyc_cnt); chk(instr_cnt); chk(pc_en);
    repeat (3) tick();
    want("h_cyc_frozen", 4); chk(cyc_cnt);
    resume = 1;
    tick();
    resume = 0;
    want("resume_halted", 0); want("resume_pc_en", 1);
    want("resume_cyc", 4);
    chk(halted); chk(pc_en); chk(cyc_cnt);
    tick();
    want("resume_cyc_runs", 5); chk(cyc_cnt);

    // saturation at CNT_W=4
    do_reset();
    ex_redirect = 1;
    repeat (20) tick();
    ex_redirect = 0;
    want("sat_flush", 15); want("sat_cyc", 15);
    chk(flush_cnt); chk(cyc_cnt);

    // async reset in the middle of DRAIN
    do_reset();
    id_halt = 1;
    tick();
    id_halt = 0;
    want("md_drain_pc_en", 0);
    chk(pc_en);
    #2;
    RST = 1'b1;
    #1;
    want("md_rst_pc_en", 1); want("md_rst_ifid_flush", 0);
    want("md_rst_cyc", 0);   want("md_rst_flush", 0);
    chk(pc_en); chk(ifid_flush); chk(cyc_cnt); chk(flush_cnt);
    RST = 1'b0;
    tick();
    want("md_run_pc_en", 1); want("md_run_cyc", 1);
    chk(pc_en); chk(cyc_cnt);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
